// File: rtl/sha3_nonce_sequencer.sv
// Job sequencer for the SHA3 scanner: walks a nonce range in scanner-sized chunks,
// resumes after every hit and queues in-range hits in a first-word-fall-through FIFO.
module sha3_nonce_sequencer #(
    parameter int INPUT_ELEMENTS = 20,
    parameter int NONCE_INDEX    = 19,
    parameter int RESULT_DEPTH   = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           job_valid,
    output logic                           job_ready,
    input  logic [INPUT_ELEMENTS-1:0][31:0] job_blobby,
    input  logic [63:0]                    job_threshold,
    input  logic [31:0]                    job_first,
    input  logic [31:0]                    job_last,
    input  logic                           job_abort,
    input  logic                           scn_idle,
    input  logic                           scn_found,
    input  logic [31:0]                    scn_nonce,
    input  logic [31:0]                    scan_count,
    output logic                           scn_start,
    output logic [INPUT_ELEMENTS-1:0][31:0] scn_blobby,
    output logic [63:0]                    scn_threshold,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [31:0]                    res_nonce,
    output logic                           busy,
    output logic                           job_done,
    output logic [15:0]                    found_count
);

    localparam int AW = $clog2(RESULT_DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_ACK    = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    logic [2:0]  state_reg;
    logic [31:0] cursor_reg;
    logic [31:0] last_reg;
    logic [63:0] threshold_reg;
    logic        start_reg;
    logic        abort_reg;
    logic [15:0] found_count_reg;
    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;
    logic [31:0] fifo_mem [RESULT_DEPTH];

    logic [31:0] chunk_len;
    logic        hit_ok;
    logic [32:0] next_nonce;
    logic        fifo_full;
    logic        fifo_pop;
    logic        fifo_push;
    logic        run_eval;
    logic        run_stop;
    logic        accept;

    // The nonce word of the template is always replaced by the cursor.
    logic unused_nonce_word;
    assign unused_nonce_word = ^job_blobby[NONCE_INDEX];

    assign accept     = (state_reg == S_IDLE) && job_valid;
    assign chunk_len  = (scan_count == 32'd0) ? 32'd1 : scan_count;
    assign hit_ok     = scn_found && (scn_nonce <= last_reg);
    assign next_nonce = hit_ok ? ({1'b0, scn_nonce} + 33'd1)
                               : ({1'b0, cursor_reg} + {1'b0, chunk_len});

    assign fifo_full = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                       (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign res_valid = (wr_ptr_reg != rd_ptr_reg);
    assign fifo_pop  = res_valid && res_ready;
    assign res_nonce = res_valid ? fifo_mem[rd_ptr_reg[AW-1:0]] : 32'd0;

    // A full FIFO only blocks the chunk evaluation when this hit has to be stored.
    assign run_eval  = (state_reg == S_RUN) && scn_idle && (!hit_ok || !fifo_full || fifo_pop);
    assign fifo_push = run_eval && hit_ok;
    assign run_stop  = next_nonce[32] || (next_nonce[31:0] > last_reg) || abort_reg || job_abort;

    assign job_ready     = (state_reg == S_IDLE);
    assign busy          = (state_reg != S_IDLE);
    assign job_done      = (state_reg == S_FINISH);
    assign scn_start     = start_reg;
    assign scn_threshold = threshold_reg;
    assign found_count   = found_count_reg;

    generate
        for (genvar gi = 0; gi < INPUT_ELEMENTS; gi++) begin : g_word
            if (gi == NONCE_INDEX) begin : g_nonce
                assign scn_blobby[gi] = cursor_reg;
            end else begin : g_tmpl
                logic [31:0] word_reg;
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        word_reg <= '0;
                    end else if (accept) begin
                        word_reg <= job_blobby[gi];
                    end
                end
                assign scn_blobby[gi] = word_reg;
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= S_IDLE;
            cursor_reg      <= '0;
            last_reg        <= '0;
            threshold_reg   <= '0;
            start_reg       <= 1'b0;
            abort_reg       <= 1'b0;
            found_count_reg <= '0;
        end else begin
            start_reg <= 1'b0;
            // Abort is latched so a short pulse still ends the job at the chunk boundary.
            if (state_reg != S_IDLE && job_abort) begin
                abort_reg <= 1'b1;
            end
            case (state_reg)
                S_IDLE: begin
                    if (job_valid) begin
                        threshold_reg   <= job_threshold;
                        cursor_reg      <= job_first;
                        last_reg        <= job_last;
                        found_count_reg <= '0;
                        abort_reg       <= 1'b0;
                        state_reg       <= (job_first > job_last) ? S_FINISH : S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    if (scn_idle) begin
                        start_reg <= 1'b1;
                        state_reg <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (!scn_idle) begin
                        state_reg <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (run_eval) begin
                        if (fifo_push && found_count_reg != 16'hFFFF) begin
                            found_count_reg <= found_count_reg + 16'd1;
                        end
                        if (run_stop) begin
                            state_reg <= S_FINISH;
                        end else begin
                            cursor_reg <= next_nonce[31:0];
                            state_reg  <= S_LAUNCH;
                        end
                    end
                end
                S_FINISH: state_reg <= S_IDLE;
                default:  state_reg <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (fifo_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr_reg[AW-1:0]] <= scn_nonce;
        end
    end

endmodule

// File: tb/tb_sha3_nonce_sequencer.sv
// Scoreboard bench: a small scanner model answers every start; expected starts, results
// and job completions are queued at issue time and checked by a separate monitor.
module tb_sha3_nonce_sequencer;

    localparam int IE        = 20;
    localparam int NI        = 19;
    localparam int SCAN_BUSY = 6;

    logic                clk = 1'b0;
    logic                rst;
    logic                job_valid;
    logic                job_ready;
    logic [IE-1:0][31:0] job_blobby;
    logic [63:0]         job_threshold;
    logic [31:0]         job_first;
    logic [31:0]         job_last;
    logic                job_abort;
    logic                scn_idle;
    logic                scn_found;
    logic [31:0]         scn_nonce;
    logic [31:0]         scan_count;
    logic                scn_start;
    logic [IE-1:0][31:0] scn_blobby;
    logic [63:0]         scn_threshold;
    logic                res_valid;
    logic                res_ready;
    logic [31:0]         res_nonce;
    logic                busy;
    logic                job_done;
    logic [15:0]         found_count;

    sha3_nonce_sequencer #(.INPUT_ELEMENTS(IE), .NONCE_INDEX(NI), .RESULT_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .job_valid(job_valid), .job_ready(job_ready), .job_blobby(job_blobby),
        .job_threshold(job_threshold), .job_first(job_first), .job_last(job_last),
        .job_abort(job_abort),
        .scn_idle(scn_idle), .scn_found(scn_found), .scn_nonce(scn_nonce),
        .scan_count(scan_count), .scn_start(scn_start), .scn_blobby(scn_blobby),
        .scn_threshold(scn_threshold),
        .res_valid(res_valid), .res_ready(res_ready), .res_nonce(res_nonce),
        .busy(busy), .job_done(job_done), .found_count(found_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int job_id = 1;

    logic [31:0] exp_start_q[$];
    logic [31:0] exp_res_q[$];
    logic [15:0] exp_done_q[$];
    logic [31:0] exp_word0;
    logic [31:0] exp_word18;
    logic [63:0] exp_thr;

    // Scanner model behaviour: 0 = never hits, 1 = hits at hit_fixed if in chunk, 2 = hits at start+5
    int          scn_mode = 0;
    logic [31:0] hit_fixed = 32'd0;
    logic [31:0] cur_start = 32'd0;
    int          busy_left = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (scn_start) begin
            cur_start = scn_blobby[NI];
            busy_left = SCAN_BUSY;
            scn_idle  = 1'b0;
            scn_found = 1'b0;
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) begin
                scn_idle = 1'b1;
                if (scn_mode == 1 && hit_fixed >= cur_start && (hit_fixed - cur_start) < scan_count) begin
                    scn_found = 1'b1;
                    scn_nonce = hit_fixed;
                end else if (scn_mode == 2) begin
                    scn_found = 1'b1;
                    scn_nonce = cur_start + 32'd5;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            if (scn_start) begin
                if (exp_start_q.size() == 0) begin
                    check("unexpected_start", {32'd0, scn_blobby[NI]}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    check("start_nonce", scn_blobby[NI], exp_start_q.pop_front());
                    check("start_word0", scn_blobby[0], exp_word0);
                    check("start_word18", scn_blobby[18], exp_word18);
                    check("start_threshold", scn_threshold, exp_thr);
                end
                $display("start nonce=%08h", scn_blobby[NI]);
            end
            if (res_valid && res_ready) begin
                if (exp_res_q.size() == 0) begin
                    check("unexpected_result", {32'd0, res_nonce}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    check("result_nonce", res_nonce, exp_res_q.pop_front());
                end
                $display("result nonce=%08h", res_nonce);
            end
            if (job_done) begin
                done_cnt++;
                if (exp_done_q.size() == 0) begin
                    check("unexpected_job_done", {48'd0, found_count}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    check("done_found_count", found_count, exp_done_q.pop_front());
                end
                $display("job_done found_count=%0d", found_count);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] f, input logic [31:0] l);
        for (int i = 0; i < IE; i++) begin
            job_blobby[i] = {job_id[7:0], 24'(i)};
        end
        job_first     = f;
        job_last      = l;
        job_threshold = {32'hFEED_0000, f};
        exp_word0     = job_blobby[0];
        exp_word18    = job_blobby[18];
        exp_thr       = job_threshold;
        check("job_ready_before_issue", job_ready, 1'b1);
        job_valid = 1'b1;
        tick(1);
        job_valid = 1'b0;
        job_id++;
    endtask

    task automatic wait_done(input int budget);
        int target;
        target = done_cnt + 1;
        for (int c = 0; c < budget; c++) begin
            if (done_cnt >= target) break;
            @(posedge clk);
        end
        #1;
        check("job_done_within_budget", done_cnt >= target, 1'b1);
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_starts_left"}, exp_start_q.size(), 0);
        check({tag, "_results_left"}, exp_res_q.size(), 0);
        check({tag, "_dones_left"}, exp_done_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; job_valid = 1'b0; job_abort = 1'b0; res_ready = 1'b0;
        job_blobby = '0; job_threshold = '0; job_first = '0; job_last = '0;
        scn_idle = 1'b1; scn_found = 1'b0; scn_nonce = '0; scan_count = 32'd32;
        tick(3);
        check("rst_busy", busy, 1'b0);
        check("rst_job_ready", job_ready, 1'b1);
        check("rst_scn_start", scn_start, 1'b0);
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_job_done", job_done, 1'b0);
        check("rst_found_count", found_count, 16'd0);
        check("rst_blobby_nonce", scn_blobby[NI], 32'd0);
        rst = 1'b1;
        tick(2);

        // Plain range, no hits
        scn_mode = 0;
        exp_start_q = '{32'd0, 32'd32, 32'd64, 32'd96};
        exp_done_q.push_back(16'd0);
        issue(32'd0, 32'd99);
        wait_done(200);
        tick(2);
        check("t1_res_valid", res_valid, 1'b0);
        check("t1_job_ready", job_ready, 1'b1);
        check_drained("t1");

        // Hit at 40 in chunk 2, resume at 41
        scn_mode = 1; hit_fixed = 32'd40; res_ready = 1'b1;
        exp_start_q = '{32'd0, 32'd32, 32'd41, 32'd73};
        exp_res_q.push_back(32'd40);
        exp_done_q.push_back(16'd1);
        issue(32'd0, 32'd99);
        wait_done(200);
        tick(2);
        check_drained("t2");

        // Top of range: one chunk, no wrap
        scn_mode = 0; res_ready = 1'b0;
        exp_start_q = '{32'hFFFF_FFF0};
        exp_done_q.push_back(16'd0);
        issue(32'hFFFF_FFF0, 32'hFFFF_FFFF);
        wait_done(100);
        tick(20);
        check_drained("t3");

        // FIFO back-pressure: six hits into four entries
        scn_mode = 2;
        exp_start_q = '{32'd0, 32'd6, 32'd12, 32'd18, 32'd24, 32'd30};
        exp_res_q = '{32'd5, 32'd11, 32'd17, 32'd23, 32'd29, 32'd35};
        exp_done_q.push_back(16'd6);
        issue(32'd0, 32'd35);
        tick(80);
        check("t4_stall_starts_left", exp_start_q.size(), 1);
        check("t4_stall_busy", busy, 1'b1);
        check("t4_stall_res_valid", res_valid, 1'b1);
        check("t4_stall_head", res_nonce, 32'd5);
        res_ready = 1'b1;
        tick(1);
        res_ready = 1'b0;
        tick(40);
        check("t4_resumed_starts_left", exp_start_q.size(), 0);
        check("t4_second_stall_busy", busy, 1'b1);
        res_ready = 1'b1;
        wait_done(100);
        tick(10);
        check("t4_res_valid_drained", res_valid, 1'b0);
        check_drained("t4");
        res_ready = 1'b0;

        // Abort pulse during the first of ten chunks
        scn_mode = 0;
        exp_start_q = '{32'd0};
        exp_done_q.push_back(16'd0);
        issue(32'd0, 32'd319);
        for (int c = 0; c < 20 && exp_start_q.size() != 0; c++) tick(1);
        check("t5_first_start_seen", exp_start_q.size(), 0);
        job_abort = 1'b1;
        tick(1);
        job_abort = 1'b0;
        wait_done(100);
        tick(20);
        check_drained("t5");

        // Empty range: done one cycle after accept, no start
        exp_done_q.push_back(16'd0);
        issue(32'd10, 32'd5);
        check("t5b_done_after_accept", job_done, 1'b1);
        tick(10);
        check_drained("t5b");

        // Reset while running, with a result pending in the FIFO
        scn_mode = 1; hit_fixed = 32'd3;
        exp_start_q = '{32'd0, 32'd4};
        issue(32'd0, 32'd319);
        for (int c = 0; c < 60 && exp_start_q.size() != 0; c++) tick(1);
        check("t6_second_start_seen", exp_start_q.size(), 0);
        tick(2);
        check("t6_running_busy", busy, 1'b1);
        check("t6_res_pending", res_valid, 1'b1);
        rst = 1'b0;
        #1;
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_job_ready", job_ready, 1'b1);
        check("t6_rst_res_valid", res_valid, 1'b0);
        check("t6_rst_job_done", job_done, 1'b0);
        exp_start_q.delete();
        exp_res_q.delete();
        exp_done_q.delete();
        tick(2);
        rst = 1'b1;
        tick(1);
        scn_mode = 0;
        exp_start_q = '{32'd100};
        exp_done_q.push_back(16'd0);
        issue(32'd100, 32'd131);
        wait_done(100);
        tick(2);
        check("t6_res_valid_after", res_valid, 1'b0);
        check_drained("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
